// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default geometry, FSM encoding
// and a width helper used to size index and beat counters.
package mem_arbiter_pkg;

    localparam int DEF_NUM_DEV   = 3;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_BURST_LEN = 4;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_ISSUE = 2'd1,
        MA_BURST = 2'd2,
        MA_DONE  = 2'd3
    } ma_state_e;

    // Bit width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin pick: scans the request vector starting at i_start
// (wrapping) and returns the first requester as one-hot grant plus index.
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
#(
    parameter int N     = DEF_NUM_DEV,
    parameter int IDX_W = clog2_min1(DEF_NUM_DEV)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int w_sum;
    int w_pos;

    // Walk the ring from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = 0;
        w_pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum   = int'(i_start) + k;
            w_pos   = (w_sum >= N) ? (w_sum - N) : w_sum;
            o_gnt   = i_req[w_pos[IDX_W-1:0]] ? (N'(1) << w_pos) : o_gnt;
            o_idx   = i_req[w_pos[IDX_W-1:0]] ? w_pos[IDX_W-1:0] : o_idx;
            o_valid = o_valid | i_req[w_pos[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between NUM_DEV
// requesters; sequences single accesses and fixed-length read bursts.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_DEV   = DEF_NUM_DEV,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_DEV-1:0]        i_dev_mem_en,
    input  logic [NUM_DEV-1:0]        i_dev_burst_en,
    input  logic [NUM_DEV-1:0]        i_dev_mem_we,
    input  logic [NUM_DEV*ADDR_W-1:0] i_dev_addr,
    input  logic [NUM_DEV*DATA_W-1:0] i_dev_di,
    output logic [NUM_DEV-1:0]        o_dev_do_ack,
    output logic [DATA_W-1:0]         o_dev_do,
    output logic [NUM_DEV-1:0]        o_grant,
    output logic                      o_mem_en,
    output logic                      o_mem_we,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_di,
    input  logic [DATA_W-1:0]         i_mem_do
);

    localparam int IDX_W = clog2_min1(NUM_DEV);
    localparam int CNT_W = clog2_min1(BURST_LEN);

    ma_state_e          r_state, w_state_nx;
    logic [NUM_DEV-1:0] r_grant, w_grant_nx;
    logic [NUM_DEV-1:0] r_ack, w_ack_nx;
    logic               r_mem_en, w_mem_en_nx;
    logic               r_mem_we, w_mem_we_nx;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nx;
    logic [DATA_W-1:0]  r_mem_di, w_mem_di_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]   r_last, w_last_nx;

    logic [IDX_W-1:0]   w_start;
    logic [NUM_DEV-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_di;
    logic               w_sel_we;
    logic               w_sel_burst;

    assign w_start = (r_last == IDX_W'(NUM_DEV - 1)) ? '0 : (r_last + IDX_W'(1));

    mem_arbiter_rr #(
        .N     (NUM_DEV),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (i_dev_mem_en),
        .i_start (w_start),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_sel_addr  = i_dev_addr[w_pick_idx*ADDR_W +: ADDR_W];
    assign w_sel_di    = i_dev_di[w_pick_idx*DATA_W +: DATA_W];
    assign w_sel_we    = i_dev_mem_we[w_pick_idx];
    // A burst request that also asks to write is served as a single write.
    assign w_sel_burst = i_dev_burst_en[w_pick_idx] & ~i_dev_mem_we[w_pick_idx];

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        w_state_nx    = r_state;
        w_grant_nx    = r_grant;
        w_mem_en_nx   = r_mem_en;
        w_mem_we_nx   = r_mem_we;
        w_mem_addr_nx = r_mem_addr;
        w_mem_di_nx   = r_mem_di;
        w_cnt_nx      = r_cnt;
        w_last_nx     = r_last;
        w_ack_nx      = r_grant & {NUM_DEV{r_mem_en}};
        case (r_state)
            MA_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nx    = w_pick_gnt;
                    w_last_nx     = w_pick_idx;
                    w_mem_en_nx   = 1'b1;
                    w_mem_we_nx   = w_sel_we;
                    w_mem_addr_nx = w_sel_addr;
                    w_mem_di_nx   = w_sel_di;
                    w_cnt_nx      = '0;
                    w_state_nx    = w_sel_burst ? MA_BURST : MA_ISSUE;
                end else begin
                    w_state_nx    = MA_IDLE;
                end
            end
            MA_ISSUE: begin
                w_mem_en_nx = 1'b0;
                w_mem_we_nx = 1'b0;
                w_state_nx  = MA_DONE;
            end
            MA_BURST: begin
                if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
                    w_mem_en_nx = 1'b0;
                    w_state_nx  = MA_DONE;
                end else begin
                    w_mem_addr_nx = r_mem_addr + ADDR_W'(1);
                    w_cnt_nx      = r_cnt + CNT_W'(1);
                end
            end
            MA_DONE: begin
                w_grant_nx = '0;
                w_state_nx = MA_IDLE;
            end
            default: begin
                w_grant_nx  = '0;
                w_mem_en_nx = 1'b0;
                w_mem_we_nx = 1'b0;
                w_state_nx  = MA_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= MA_IDLE;
            r_grant    <= '0;
            r_ack      <= '0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_di   <= '0;
            r_cnt      <= '0;
            r_last     <= IDX_W'(NUM_DEV - 1);
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_ack      <= w_ack_nx;
            r_mem_en   <= w_mem_en_nx;
            r_mem_we   <= w_mem_we_nx;
            r_mem_addr <= w_mem_addr_nx;
            r_mem_di   <= w_mem_di_nx;
            r_cnt      <= w_cnt_nx;
            r_last     <= w_last_nx;
        end
    end

    assign o_dev_do_ack = r_ack;
    assign o_grant      = r_grant;
    assign o_mem_en     = r_mem_en;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_di     = r_mem_di;
    // RAM output is already registered; forward it only while an ack is shown.
    assign o_dev_do     = (|r_ack) ? i_mem_do : '0;

endmodule
